// File: rtl/uncache_ctrl_pkg.sv
// Shared types and constants for the uncached access sequencer.
// Covers FSM states, request owner, access size codes and kseg decoding.
package uncache_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } uncache_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // vaddr[31:30] == 2'b10 selects kseg0/kseg1; the top three bits are stripped.
    localparam logic [1:0] KSEG01_TOP = 2'b10;
    localparam int         KSEG_STRIP = 3;

endpackage

// File: rtl/uncache_ctrl_rr_arb2.sv
// Two-input round-robin arbiter: on a tie the side that did not win last time wins.
// Grants are combinational and only offered while grant_en is high.
module uncache_ctrl_rr_arb2
    import uncache_ctrl_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic req_i,
    input  logic req_d,
    input  logic grant_en,
    output logic gnt_i,
    output logic gnt_d
);

    owner_t last_grant_reg;

    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (grant_en) begin
            if (req_i && req_d) begin
                if (last_grant_reg == OWN_I) begin
                    gnt_d = 1'b1;
                end else begin
                    gnt_i = 1'b1;
                end
            end else begin
                gnt_i = req_i;
                gnt_d = req_d;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant_reg <= OWN_I;
        end else if (gnt_i) begin
            last_grant_reg <= OWN_I;
        end else if (gnt_d) begin
            last_grant_reg <= OWN_D;
        end
    end

endmodule

// File: rtl/uncache_ctrl.sv
// Uncached access sequencer: arbitrates fetch/data requests and runs one
// transaction at a time on the SRAM-like uncached bus port.
module uncache_ctrl
    import uncache_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              i_cancel,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [DATA_W-1:0] d_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    uncache_state_t    state_reg, state_next;
    owner_t            owner_reg, owner_next;
    logic              wr_reg, wr_next;
    logic [1:0]        size_reg, size_next;
    logic [ADDR_W-1:0] paddr_reg, paddr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              drop_reg, drop_next;
    logic              gnt_i, gnt_d;

    function automatic logic [ADDR_W-1:0] xlate(input logic [ADDR_W-1:0] vaddr);
        if (vaddr[ADDR_W-1 -: 2] == KSEG01_TOP) begin
            return {{KSEG_STRIP{1'b0}}, vaddr[ADDR_W-KSEG_STRIP-1:0]};
        end
        return vaddr;
    endfunction

    uncache_ctrl_rr_arb2 u_arb (
        .clk      (clk),
        .resetn   (resetn),
        .req_i    (i_req),
        .req_d    (d_req),
        .grant_en (state_reg == IDLE),
        .gnt_i    (gnt_i),
        .gnt_d    (gnt_d)
    );

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        wr_next    = wr_reg;
        size_next  = size_reg;
        paddr_next = paddr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        drop_next  = drop_reg;

        // A flush only matters once a fetch owns the bus; the bus cycle still finishes.
        if (i_cancel && (state_reg != IDLE) && (owner_reg == OWN_I)) begin
            drop_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                drop_next = 1'b0;
                if (gnt_d) begin
                    state_next = ADDR;
                    owner_next = OWN_D;
                    wr_next    = d_wr;
                    size_next  = d_size;
                    paddr_next = xlate(d_addr);
                    wdata_next = d_wdata;
                end else if (gnt_i) begin
                    state_next = ADDR;
                    owner_next = OWN_I;
                    wr_next    = 1'b0;
                    size_next  = SIZE_WORD;
                    paddr_next = xlate(i_addr);
                    wdata_next = '0;
                end
            end
            ADDR: begin
                if (bus_addr_ok) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bus_data_ok) begin
                    rdata_next = bus_rdata;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
                drop_next  = 1'b0;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            owner_reg <= OWN_I;
            wr_reg    <= 1'b0;
            size_reg  <= 2'd0;
            paddr_reg <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            drop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            wr_reg    <= wr_next;
            size_reg  <= size_next;
            paddr_reg <= paddr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            drop_reg  <= drop_next;
        end
    end

    assign i_addr_ok = gnt_i;
    assign d_addr_ok = gnt_d;
    assign i_data_ok = (state_reg == RESP) && (owner_reg == OWN_I) && !drop_reg;
    assign d_data_ok = (state_reg == RESP) && (owner_reg == OWN_D);
    assign i_rdata   = rdata_reg;
    assign d_rdata   = rdata_reg;

    assign bus_req   = (state_reg == ADDR);
    assign bus_wr    = wr_reg;
    assign bus_size  = size_reg;
    assign bus_addr  = paddr_reg;
    assign bus_wdata = wdata_reg;

endmodule

// File: tb/tb_uncache_ctrl.sv
// Directed self-checking bench for uncache_ctrl; the bench plays the bus side.
// Inputs change just after each falling edge, outputs are sampled 1 ns later.
module tb_uncache_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_addr_ok, i_data_ok;
    logic [31:0] i_rdata;
    logic        i_cancel = 1'b0;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [1:0]  d_size = 2'd2;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_addr_ok, d_data_ok;
    logic [31:0] d_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok = 1'b0;
    logic        bus_data_ok = 1'b0;
    logic [31:0] bus_rdata = '0;

    int tests = 0;
    int fails = 0;

    uncache_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_addr_ok   (i_addr_ok),
        .i_data_ok   (i_data_ok),
        .i_rdata     (i_rdata),
        .i_cancel    (i_cancel),
        .d_req       (d_req),
        .d_wr        (d_wr),
        .d_size      (d_size),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_addr_ok   (d_addr_ok),
        .d_data_ok   (d_data_ok),
        .d_rdata     (d_rdata),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_size    (bus_size),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        logic [140:0] outs;
        outs = {i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
                bus_req, bus_wr, bus_size, bus_addr, bus_wdata};
        @(negedge clk); #1;
        outs = {i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
                bus_req, bus_wr, bus_size, bus_addr, bus_wdata};
        tests++;
        if (outs !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        @(negedge clk); resetn = 1'b1;
        // walk a load into DATA, then pull reset mid-transaction
        @(negedge clk); d_req = 1'b1; d_wr = 1'b0; d_size = 2'd2; d_addr = 32'hBFAF_0004; #1;
        tests++;
        if (d_addr_ok !== 1'b1) begin fails++; $display("FAIL pre_reset_grant: got %b expected 1", d_addr_ok); end
        @(negedge clk); d_req = 1'b0; bus_addr_ok = 1'b1; #1;
        tests++;
        if (bus_req !== 1'b1) begin fails++; $display("FAIL pre_reset_bus_req: got %b expected 1", bus_req); end
        @(negedge clk); bus_addr_ok = 1'b0; #1;
        resetn = 1'b0; #1;
        outs = {i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
                bus_req, bus_wr, bus_size, bus_addr, bus_wdata};
        tests++;
        if (outs !== '0) begin fails++; $display("FAIL midtxn_reset_outputs: got %h expected 0", outs); end
        @(negedge clk); resetn = 1'b1; bus_data_ok = 1'b1; #1;
        tests++;
        if ({d_data_ok, bus_req} !== 2'b00) begin
            fails++; $display("FAIL post_reset_idle: data_ok,bus_req=%b expected 00", {d_data_ok, bus_req});
        end
        @(negedge clk); bus_data_ok = 1'b0; #1;
        tests++;
        if (d_data_ok !== 1'b0) begin fails++; $display("FAIL post_reset_no_data_ok: got %b expected 0", d_data_ok); end
        // best-case load: accept c0, bus c1, data c2, d_data_ok c3
        @(negedge clk); d_req = 1'b1; d_addr = 32'hBFAF_F000; #1;
        tests++;
        if ({d_addr_ok, i_addr_ok} !== 2'b10) begin
            fails++; $display("FAIL load_grant: d,i addr_ok=%b expected 10", {d_addr_ok, i_addr_ok});
        end
        @(negedge clk); d_req = 1'b0; bus_addr_ok = 1'b1; #1;
        tests++;
        if ({bus_req, bus_wr, bus_size, bus_addr} !== {1'b1, 1'b0, 2'd2, 32'h1FAF_F000}) begin
            fails++; $display("FAIL load_bus_fields: req=%b wr=%b size=%0d addr=%h expected 1 0 2 1faff000",
                              bus_req, bus_wr, bus_size, bus_addr);
        end
        @(negedge clk); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678; #1;
        tests++;
        if (d_data_ok !== 1'b0) begin fails++; $display("FAIL load_early_data_ok: got %b expected 0", d_data_ok); end
        @(negedge clk); bus_data_ok = 1'b0; bus_rdata = '0; #1;
        tests++;
        if ({d_data_ok, d_rdata} !== {1'b1, 32'h1234_5678}) begin
            fails++; $display("FAIL load_data: data_ok=%b rdata=%h expected 1 12345678", d_data_ok, d_rdata);
        end
        @(negedge clk); #1;
        tests++;
        if (d_data_ok !== 1'b0) begin fails++; $display("FAIL load_pulse_width: got %b expected 0", d_data_ok); end
    endtask

    task automatic test_tie();
        logic [9:0]  ia, da, br, ido, ddo;
        logic [31:0] ba1, ba5, dr3, ir7;
        logic        clr_i, clr_d;
        clr_i = 1'b0; clr_d = 1'b0;
        ba1 = '0; ba5 = '0; dr3 = '0; ir7 = '0;
        @(negedge clk); resetn = 1'b0;
        @(negedge clk); resetn = 1'b1;
        i_addr = 32'hBFAF_0000; d_addr = 32'hBFAF_0100; d_wr = 1'b0; d_size = 2'd2;
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin i_req = 1'b1; d_req = 1'b1; end
            if (clr_i) begin i_req = 1'b0; clr_i = 1'b0; end
            if (clr_d) begin d_req = 1'b0; clr_d = 1'b0; end
            bus_rdata = 32'hAAAA_0000 + 32'(c);
            #1;
            ia[c] = i_addr_ok; da[c] = d_addr_ok; br[c] = bus_req;
            ido[c] = i_data_ok; ddo[c] = d_data_ok;
            if (i_addr_ok) clr_i = 1'b1;
            if (d_addr_ok) clr_d = 1'b1;
            if (c == 1) ba1 = bus_addr;
            if (c == 5) ba5 = bus_addr;
            if (c == 3) dr3 = d_rdata;
            if (c == 7) ir7 = i_rdata;
        end
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
        tests++;
        if (da !== 10'b00_0000_0001) begin fails++; $display("FAIL tie_d_addr_ok: got %b expected 0000000001", da); end
        tests++;
        if (ia !== 10'b00_0001_0000) begin fails++; $display("FAIL tie_i_addr_ok: got %b expected 0000010000", ia); end
        tests++;
        if (br !== 10'b00_0010_0010) begin fails++; $display("FAIL tie_bus_req: got %b expected 0000100010", br); end
        tests++;
        if (ddo !== 10'b00_0000_1000) begin fails++; $display("FAIL tie_d_data_ok: got %b expected 0000001000", ddo); end
        tests++;
        if (ido !== 10'b00_1000_0000) begin fails++; $display("FAIL tie_i_data_ok: got %b expected 0010000000", ido); end
        tests++;
        if ({ba1, ba5} !== {32'h1FAF_0100, 32'h1FAF_0000}) begin
            fails++; $display("FAIL tie_bus_addr: got %h %h expected 1faf0100 1faf0000", ba1, ba5);
        end
        tests++;
        if ({dr3, ir7} !== {32'hAAAA_0002, 32'hAAAA_0006}) begin
            fails++; $display("FAIL tie_rdata: got %h %h expected aaaa0002 aaaa0006", dr3, ir7);
        end
    endtask

    task automatic test_bus_stall();
        int pulses;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                d_req = 1'b1; d_wr = 1'b1; d_size = 2'd0;
                d_addr = 32'hBFAF_8000; d_wdata = 32'hDEAD_BEEF;
            end
            if (c == 1) d_req = 1'b0;
            bus_addr_ok = (c == 5);
            bus_data_ok = (c == 6);
            #1;
            if (d_data_ok) pulses++;
            if (c == 0) begin
                tests++;
                if (d_addr_ok !== 1'b1) begin fails++; $display("FAIL stall_grant: got %b expected 1", d_addr_ok); end
            end
            if (c >= 1 && c <= 5) begin
                tests++;
                if ({bus_req, bus_wr, bus_size, bus_addr, bus_wdata} !==
                    {1'b1, 1'b1, 2'd0, 32'h1FAF_8000, 32'hDEAD_BEEF}) begin
                    fails++;
                    $display("FAIL stall_fields c%0d: req=%b wr=%b size=%0d addr=%h wdata=%h expected 1 1 0 1faf8000 deadbeef",
                             c, bus_req, bus_wr, bus_size, bus_addr, bus_wdata);
                end
            end
            if (c == 6) begin
                tests++;
                if (bus_req !== 1'b0) begin fails++; $display("FAIL stall_req_drop: got %b expected 0", bus_req); end
            end
            if (c == 7) begin
                tests++;
                if (d_data_ok !== 1'b1) begin fails++; $display("FAIL stall_data_ok: got %b expected 1", d_data_ok); end
            end
        end
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; d_wr = 1'b0; d_size = 2'd2; d_wdata = '0;
        tests++;
        if (pulses != 1) begin fails++; $display("FAIL stall_pulse_count: got %0d expected 1", pulses); end
    endtask

    task automatic test_cancel();
        int i_pulses, d_pulses;
        i_pulses = 0; d_pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin i_req = 1'b1; i_addr = 32'hBFAF_0010; end
            if (c == 1 || c == 6) i_req = 1'b0;
            if (c == 5) begin i_req = 1'b1; i_addr = 32'hBFAF_0020; end
            bus_addr_ok = (c == 1 || c == 6);
            i_cancel    = (c == 2);
            bus_data_ok = (c == 3 || c == 7);
            bus_rdata   = (c == 3) ? 32'hCAFE_0001 : 32'h1357_9BDF;
            #1;
            if (c <= 7 && i_data_ok) i_pulses++;
            if (d_data_ok) d_pulses++;
            if (c == 0) begin
                tests++;
                if (i_addr_ok !== 1'b1) begin fails++; $display("FAIL cancel_grant: got %b expected 1", i_addr_ok); end
            end
            if (c == 1) begin
                tests++;
                if ({bus_req, bus_wr, bus_size, bus_addr} !== {1'b1, 1'b0, 2'd2, 32'h1FAF_0010}) begin
                    fails++; $display("FAIL cancel_fetch_fields: req=%b wr=%b size=%0d addr=%h expected 1 0 2 1faf0010",
                                      bus_req, bus_wr, bus_size, bus_addr);
                end
            end
            if (c == 5) begin
                tests++;
                if (i_addr_ok !== 1'b1) begin fails++; $display("FAIL cancel_next_grant: got %b expected 1", i_addr_ok); end
            end
            if (c == 6) begin
                tests++;
                if (bus_addr !== 32'h1FAF_0020) begin fails++; $display("FAIL cancel_next_addr: got %h expected 1faf0020", bus_addr); end
            end
            if (c == 8) begin
                tests++;
                if ({i_data_ok, i_rdata} !== {1'b1, 32'h1357_9BDF}) begin
                    fails++; $display("FAIL cancel_next_data: data_ok=%b rdata=%h expected 1 13579bdf", i_data_ok, i_rdata);
                end
            end
        end
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
        tests++;
        if (i_pulses != 0) begin fails++; $display("FAIL cancel_suppressed: got %0d i_data_ok pulses expected 0", i_pulses); end
        tests++;
        if (d_pulses != 0) begin fails++; $display("FAIL cancel_no_d_data_ok: got %0d pulses expected 0", d_pulses); end
    endtask

    task automatic test_addr_map();
        logic [31:0] va [3];
        logic [31:0] pa [3];
        logic        dside [3];
        va[0] = 32'h9FC0_0000; pa[0] = 32'h1FC0_0000; dside[0] = 1'b1;
        va[1] = 32'h0000_1000; pa[1] = 32'h0000_1000; dside[1] = 1'b0;
        va[2] = 32'hC000_0004; pa[2] = 32'hC000_0004; dside[2] = 1'b1;
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus_rdata = 32'h5A00_0000 + 32'(k);
            if (dside[k]) begin d_req = 1'b1; d_addr = va[k]; end
            else begin i_req = 1'b1; i_addr = va[k]; end
            @(negedge clk); d_req = 1'b0; i_req = 1'b0; #1;
            tests++;
            if (bus_addr !== pa[k]) begin
                fails++; $display("FAIL map_paddr %h: got %h expected %h", va[k], bus_addr, pa[k]);
            end
            @(negedge clk);
            @(negedge clk); #1;
            tests++;
            if ({d_data_ok, i_data_ok, d_rdata} !== {dside[k], !dside[k], 32'h5A00_0000 + 32'(k)}) begin
                fails++; $display("FAIL map_resp %h: d_ok=%b i_ok=%b rdata=%h", va[k], d_data_ok, i_data_ok, d_rdata);
            end
        end
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    endtask

    initial begin
        test_reset();
        test_tie();
        test_bus_stall();
        test_cancel();
        test_addr_map();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
